// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined carry-lookahead add/sub, one GROUP-bit group resolved per stage
// Optional clamp-on-overflow enabled by defining CLA_SATURATE_EN.
module cla_addsub_pipe #(
   parameter int WIDTH = 12,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);
   localparam int NG = WIDTH / GROUP;
   localparam int NM = (NG > 1) ? NG - 1 : 1;

   // Intermediate stages carry operands, partial sum and group carry-out.
   logic [NG-1:0]    vld_q, vld_d;
   logic [WIDTH-1:0] ma_q [NM];
   logic [WIDTH-1:0] ma_d [NM];
   logic [WIDTH-1:0] mb_q [NM];
   logic [WIDTH-1:0] mb_d [NM];
   logic [WIDTH-1:0] ms_q [NM];
   logic [WIDTH-1:0] ms_d [NM];
   logic [NM-1:0]    mc_q, mc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             fn_q, fn_d, fz_q, fz_d, fc_q, fc_d, fv_q, fv_d;

   logic             advance, accept;
   logic [WIDTH-1:0] sa [NG];
   logic [WIDTH-1:0] sb [NG];
   logic [WIDTH-1:0] ss [NG];
   logic [NG-1:0]    sc_in, sc_out, sv;
   logic             carry, p, g, cmsb, vflag;
   logic [WIDTH-1:0] sum_c;

   always_comb begin
      advance = !vld_q[NG-1] || out_ready;
      accept  = in_valid && advance;

      sa[0]    = a;
      sb[0]    = op ? ~b : b;
      ss[0]    = '0;
      sc_in[0] = op | cin;
      sv[0]    = accept;
      for (int k = 1; k < NG; k++) begin
         sa[k]    = ma_q[k-1];
         sb[k]    = mb_q[k-1];
         ss[k]    = ms_q[k-1];
         sc_in[k] = mc_q[k-1];
         sv[k]    = vld_q[k-1];
      end

      cmsb  = 1'b0;
      carry = 1'b0;
      p     = 1'b0;
      g     = 1'b0;
      for (int k = 0; k < NG; k++) begin
         carry = sc_in[k];
         for (int i = 0; i < GROUP; i++) begin
            p = sa[k][k*GROUP+i] ^ sb[k][k*GROUP+i];
            g = sa[k][k*GROUP+i] & sb[k][k*GROUP+i];
            ss[k][k*GROUP+i] = p ^ carry;
            if (k*GROUP + i == WIDTH - 1) cmsb = carry;
            carry = g | (p & carry);
         end
         sc_out[k] = carry;
      end

      sum_c = ss[NG-1];
      vflag = sc_out[NG-1] ^ cmsb;
`ifdef CLA_SATURATE_EN
      // Carry into MSB without carry out means the true result was positive.
      if (vflag)
         sum_c = cmsb ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif

      for (int k = 0; k < NM; k++) begin
         ma_d[k] = ma_q[k];
         mb_d[k] = mb_q[k];
         ms_d[k] = ms_q[k];
      end
      mc_d  = mc_q;
      vld_d = vld_q;
      res_d = res_q;
      fn_d  = fn_q;
      fz_d  = fz_q;
      fc_d  = fc_q;
      fv_d  = fv_q;

      if (advance) begin
         for (int k = 0; k < NG - 1; k++) begin
            ma_d[k]  = sa[k];
            mb_d[k]  = sb[k];
            ms_d[k]  = ss[k];
            mc_d[k]  = sc_out[k];
            vld_d[k] = sv[k];
         end
         vld_d[NG-1] = sv[NG-1];
         res_d = sum_c;
         fn_d  = sum_c[WIDTH-1];
         fz_d  = (sum_c == '0);
         fc_d  = sc_out[NG-1];
         fv_d  = vflag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < NM; k++) begin
            ma_q[k] <= '0;
            mb_q[k] <= '0;
            ms_q[k] <= '0;
         end
         mc_q  <= '0;
         res_q <= '0;
         fn_q  <= 1'b0;
         fz_q  <= 1'b0;
         fc_q  <= 1'b0;
         fv_q  <= 1'b0;
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < NM; k++) begin
            ma_q[k] <= ma_d[k];
            mb_q[k] <= mb_d[k];
            ms_q[k] <= ms_d[k];
         end
         mc_q  <= mc_d;
         res_q <= res_d;
         fn_q  <= fn_d;
         fz_q  <= fz_d;
         fc_q  <= fc_d;
         fv_q  <= fv_d;
      end
   end

   assign in_ready  = advance;
   assign out_valid = vld_q[NG-1];
   assign result    = res_q;
   assign flag_n    = fn_q;
   assign flag_z    = fz_q;
   assign flag_c    = fc_q;
   assign flag_v    = fv_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - directed self-checking bench for cla_addsub_pipe
module tb_cla_addsub_pipe;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] a;
   logic [11:0] b;
   logic        op;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] result;
   logic        flag_n, flag_z, flag_c, flag_v;

   int total  = 0;
   int passes = 0;
   int fails  = 0;

   cla_addsub_pipe #(.WIDTH(12), .GROUP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Flags are compared as {N,Z,C,V}.
   task automatic run_one(input string tag, input logic [11:0] va, input logic [11:0] vb,
                          input logic vop, input logic vcin,
                          input logic [11:0] er, input logic [3:0] ef);
      int n;
      @(negedge clk);
      a = va; b = vb; op = vop; cin = vcin; in_valid = 1'b1;
      #1;
      check({tag, "_in_ready"}, 16'(in_ready), 16'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, 16'(n), 16'd3);
      check({tag, "_result"}, 16'(result), 16'(er));
      check({tag, "_nzcv"}, 16'({flag_n, flag_z, flag_c, flag_v}), 16'(ef));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent, recv, extra;
      logic [11:0] held;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; cin = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 16'(out_valid), 16'd0);
      check("rst_result", 16'(result), 16'd0);
      check("rst_flags", 16'({flag_n, flag_z, flag_c, flag_v}), 16'd0);
      check("rst_in_ready", 16'(in_ready), 16'd1);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef CLA_SATURATE_EN
      run_one("add_ovf_pos", 12'h7FF, 12'h001, 1'b0, 1'b0, 12'h7FF, 4'b0001);
      run_one("sub_ovf_neg", 12'h800, 12'h001, 1'b1, 1'b0, 12'h800, 4'b1011);
      run_one("add_ovf_neg", 12'h800, 12'h800, 1'b0, 1'b0, 12'h800, 4'b1011);
`else
      run_one("add_ovf_pos", 12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 4'b1001);
      run_one("sub_ovf_neg", 12'h800, 12'h001, 1'b1, 1'b0, 12'h7FF, 4'b0011);
      run_one("add_ovf_neg", 12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 4'b0111);
`endif
      run_one("sub_equal", 12'h005, 12'h005, 1'b1, 1'b0, 12'h000, 4'b0110);
      run_one("sub_borrow", 12'h003, 12'h005, 1'b1, 1'b0, 12'hFFE, 4'b1000);
      run_one("chain_b1", 12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 4'b0110);
      run_one("chain_cin", 12'hFFF, 12'h000, 1'b0, 1'b1, 12'h000, 4'b0110);
      run_one("chain_mid", 12'h0FF, 12'h001, 1'b0, 1'b0, 12'h100, 4'b0000);
      run_one("sub_cin_ign", 12'h00A, 12'h003, 1'b1, 1'b0, 12'h007, 4'b0010);
      run_one("add_cin", 12'h123, 12'h456, 1'b0, 1'b1, 12'h57A, 4'b0000);

      // Back-to-back stream with a two-cycle output stall in the middle.
      sent = 0; recv = 0; held = '0;
      for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc == 4 || cyc == 5);
         in_valid  = (sent < 6);
         a = 12'(sent + 1); b = 12'h100; op = 1'b0; cin = 1'b0;
         #1;
         if (cyc == 4) begin
            check("stall_in_ready", 16'(in_ready), 16'd0);
            held = result;
         end
         if (cyc == 5) begin
            check("stall_in_ready", 16'(in_ready), 16'd0);
            check("stall_out_valid", 16'(out_valid), 16'd1);
            check("stall_hold", 16'(result), 16'(held));
         end
         if (out_valid && out_ready) begin
            check("stream_result", 16'(result), 16'(12'h100 + 12'(recv + 1)));
            recv++;
         end
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("stream_recv", 16'(recv), 16'd6);
      check("stream_sent", 16'(sent), 16'd6);
      extra = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("stream_no_dup", 16'(extra), 16'd0);

      // Three operations in flight are discarded by reset.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 12'(12'h201 + i); b = 12'h000; op = 1'b0; cin = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("flight_out_valid", 16'(out_valid), 16'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst2_out_valid", 16'(out_valid), 16'd0);
      check("rst2_result", 16'(result), 16'd0);
      check("rst2_flags", 16'({flag_n, flag_z, flag_c, flag_v}), 16'd0);
      check("rst2_in_ready", 16'(in_ready), 16'd1);
      out_ready = 1'b1;
      extra = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("rst2_discarded", 16'(extra), 16'd0);
      run_one("post_rst", 12'h0AB, 12'h011, 1'b0, 1'b0, 12'h0BC, 4'b0000);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
